// File: rtl/reg_write_queue.sv
// In-order write-back queue in front of the register file's single write port.
// Define BYPASS_EN to build the read-bypass comparators; otherwise byp_* outputs are tied to 0.
module reg_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     port_busy,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_a3,
  output logic [DW-1:0]            rf_wd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  input  logic [AW-1:0]            q_a1,
  input  logic [AW-1:0]            q_a2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [DW-1:0]            byp_data1,
  output logic [DW-1:0]            byp_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rf_we    = !empty && !port_busy;
  assign rf_a3    = addr_q[rd_ptr_q];
  assign rf_wd    = data_q[rd_ptr_q];
  assign push     = in_valid && in_ready;
  assign pop      = rf_we;

  // Push only happens when not full and pop only when not empty, so the two
  // pointers never address the same slot in a cycle where both act.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      addr_d[wr_ptr_q]  = in_addr;
      data_d[wr_ptr_q]  = in_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef BYPASS_EN
  // Walk oldest to youngest from the head so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == q_a1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_q[idx];
      end
      if (valid_q[idx] && (addr_q[idx] == q_a2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_q[idx];
      end
    end
  end
`else
  logic unused_q_addr;
  assign unused_q_addr = ^{q_a1, q_a2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule
